// File: rtl/tt_pcpi_mul_bridge.sv
// rtl/tt_pcpi_mul_bridge.sv - byte-serial bridge to a shift-add RISC-V M-extension multiplier
//
// Purpose: receives an opcode byte and two XLEN-bit operands LSB-first over an
// 8-bit valid/ready link, runs a one-bit-per-cycle multiply, and returns the
// selected XLEN-bit half of the product LSB-first over the same style of link.
//
// Ports:
//   clk      - single clock, all state on the rising edge
//   rst_n    - asynchronous active-low reset
//   ena      - enable; low freezes all state
//   ui_in    - inbound data byte (opcode, rs1 bytes, rs2 bytes)
//   uo_out   - outbound result byte, 0x00 whenever out_valid is low
//   uio_in   - [0] in_valid, [1] out_ready, [7] abort
//   uio_out  - [2] in_ready, [3] out_valid, [4] busy, [5] err
//   uio_oe   - constant 8'b0011_1100
module tt_pcpi_mul_bridge #(
   parameter int XLEN = 32
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   output logic [7:0] uo_out,
   input  logic [7:0] uio_in,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   localparam int NB = XLEN / 8;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD_A,
      S_LOAD_B,
      S_COMPUTE,
      S_SEND
   } state_t;

   state_t              state_q, state_d;
   logic [7:0]          opcode_q, opcode_d;
   logic [2:0]          byte_cnt_q, byte_cnt_d;
   logic [5:0]          step_q, step_d;
   logic [XLEN-1:0]     rs1_q, rs1_d;
   logic [XLEN-1:0]     rs2_q, rs2_d;
   logic [2*XLEN-1:0]   mcand_q, mcand_d;
   logic [2*XLEN-1:0]   acc_q, acc_d;
   logic [XLEN-1:0]     mplier_q, mplier_d;
   logic [XLEN-1:0]     result_q, result_d;

   logic in_valid, out_ready, abort;
   logic in_ready, out_valid, busy, err;
   logic accept, consume, bad_op, rs1_signed, rs2_signed, last_byte;
   logic unused_bits;

   assign in_valid   = uio_in[0];
   assign out_ready  = uio_in[1];
   assign abort      = uio_in[7];
   assign unused_bits = &{1'b0, uio_in[6:2]};

   // in_ready is masked by rst_n so the link reports not-ready while held in reset.
   assign in_ready  = rst_n && (state_q == S_IDLE || state_q == S_LOAD_A || state_q == S_LOAD_B);
   assign out_valid = (state_q == S_SEND);
   assign busy      = (state_q != S_IDLE);
   assign bad_op    = |opcode_q[7:2];
   assign err       = out_valid && bad_op;

   assign accept    = ena && in_valid && in_ready;
   assign consume   = ena && out_valid && out_ready;
   assign last_byte = (byte_cnt_q == 3'(NB - 1));

   // MULH and MULHSU treat rs1 as signed; only MULH treats rs2 as signed.
   assign rs1_signed = (opcode_q[1:0] == 2'b01) || (opcode_q[1:0] == 2'b10);
   assign rs2_signed = (opcode_q[1:0] == 2'b01);

   assign uo_out  = out_valid ? result_q[7:0] : 8'h00;
   assign uio_out = {2'b00, err, busy, out_valid, in_ready, 2'b00};
   assign uio_oe  = 8'b0011_1100;

   always_comb begin
      state_d    = state_q;
      opcode_d   = opcode_q;
      byte_cnt_d = byte_cnt_q;
      step_d     = step_q;
      rs1_d      = rs1_q;
      rs2_d      = rs2_q;
      mcand_d    = mcand_q;
      acc_d      = acc_q;
      mplier_d   = mplier_q;
      result_d   = result_q;

      if (ena) begin
         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  opcode_d   = ui_in;
                  byte_cnt_d = 3'd0;
                  state_d    = S_LOAD_A;
               end
            end
            S_LOAD_A: begin
               if (accept) begin
                  rs1_d[byte_cnt_q*8 +: 8] = ui_in;
                  byte_cnt_d = last_byte ? 3'd0 : byte_cnt_q + 3'd1;
                  if (last_byte) state_d = S_LOAD_B;
               end
            end
            S_LOAD_B: begin
               if (accept) begin
                  rs2_d[byte_cnt_q*8 +: 8] = ui_in;
                  byte_cnt_d = last_byte ? 3'd0 : byte_cnt_q + 3'd1;
                  if (last_byte) begin
                     state_d = S_COMPUTE;
                     step_d  = 6'd0;
                  end
               end
            end
            S_COMPUTE: begin
               if (step_q == 6'd0) begin
                  // Setup cycle: sign/zero-extend the multiplicand to 2*XLEN bits.
                  acc_d    = '0;
                  mcand_d  = {{XLEN{rs1_q[XLEN-1] & rs1_signed}}, rs1_q};
                  mplier_d = rs2_q;
                  step_d   = 6'd1;
               end else begin
                  // A signed rs2 MSB carries weight -2^(XLEN-1): subtract on the final step.
                  if (mplier_q[0]) begin
                     if (step_q == 6'(XLEN) && rs2_signed) acc_d = acc_q - mcand_q;
                     else                                  acc_d = acc_q + mcand_q;
                  end
                  mcand_d  = mcand_q << 1;
                  mplier_d = mplier_q >> 1;
                  if (step_q == 6'(XLEN)) begin
                     state_d    = S_SEND;
                     byte_cnt_d = 3'd0;
                     if (bad_op)                     result_d = '0;
                     else if (opcode_q[1:0] == 2'b00) result_d = acc_d[XLEN-1:0];
                     else                            result_d = acc_d[2*XLEN-1:XLEN];
                  end else begin
                     step_d = step_q + 6'd1;
                  end
               end
            end
            S_SEND: begin
               if (consume) begin
                  result_d   = result_q >> 8;
                  byte_cnt_d = last_byte ? 3'd0 : byte_cnt_q + 3'd1;
                  if (last_byte) state_d = S_IDLE;
               end
            end
            default: state_d = S_IDLE;
         endcase

         // Abort overrides any accept or consume decided above.
         if (abort) begin
            state_d    = S_IDLE;
            opcode_d   = '0;
            byte_cnt_d = '0;
            step_d     = '0;
            rs1_d      = '0;
            rs2_d      = '0;
            mcand_d    = '0;
            acc_d      = '0;
            mplier_d   = '0;
            result_d   = '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         opcode_q   <= '0;
         byte_cnt_q <= '0;
         step_q     <= '0;
         rs1_q      <= '0;
         rs2_q      <= '0;
         mcand_q    <= '0;
         acc_q      <= '0;
         mplier_q   <= '0;
         result_q   <= '0;
      end else begin
         state_q    <= state_d;
         opcode_q   <= opcode_d;
         byte_cnt_q <= byte_cnt_d;
         step_q     <= step_d;
         rs1_q      <= rs1_d;
         rs2_q      <= rs2_d;
         mcand_q    <= mcand_d;
         acc_q      <= acc_d;
         mplier_q   <= mplier_d;
         result_q   <= result_d;
      end
   end

endmodule

// File: tb/tb_tt_pcpi_mul_bridge.sv
// tb/tb_tt_pcpi_mul_bridge.sv - self-checking bench for tt_pcpi_mul_bridge
module tb_tt_pcpi_mul_bridge;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ena = 1'b1;
   logic [7:0] ui_in = 8'h00;
   logic [7:0] uio_in = 8'h00;
   logic [7:0] uo_out, uio_out, uio_oe;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   tt_pcpi_mul_bridge #(.XLEN(32)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (ena),
      .ui_in   (ui_in),
      .uo_out  (uo_out),
      .uio_in  (uio_in),
      .uio_out (uio_out),
      .uio_oe  (uio_oe)
   );

   wire in_ready  = uio_out[2];
   wire out_valid = uio_out[3];
   wire busy      = uio_out[4];
   wire err       = uio_out[5];

   // Reference: exact 64-bit product of operands interpreted per opcode.
   function automatic logic [31:0] model(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] sa, sb, p;
      if (op[7:2] != 6'd0) return 32'd0;
      sa = (op[1:0] == 2'b01 || op[1:0] == 2'b10) ? $signed({{32{a[31]}}, a}) : $signed({32'd0, a});
      sb = (op[1:0] == 2'b01) ? $signed({{32{b[31]}}, b}) : $signed({32'd0, b});
      p  = sa * sb;
      return (op[1:0] == 2'b00) ? p[31:0] : p[63:32];
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL in_ready_before_byte got %b want 1", in_ready);
      end
      ui_in = b;
      uio_in[0] = 1'b1;
      tick();
      uio_in[0] = 1'b0;
      ui_in = 8'h00;
   endtask

   task automatic send_frame(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
      send_byte(op);
      for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
      for (int i = 0; i < 4; i++) send_byte(b[8*i +: 8]);
   endtask

   // Waits for the result (counting every edge, enabled or not), optionally
   // freezes ena for 5 cycles at edge gap_at, optionally stalls out_ready.
   task automatic get_result(input logic [7:0] op, input int exp_lat, input int gap_at,
                             input int stall, output logic [31:0] r);
      int n;
      int w;
      logic [7:0] b0;
      logic exp_err;
      exp_err = (op[7:2] != 6'd0);
      r = 32'd0;
      n = 0;
      while (out_valid !== 1'b1 && n < 200) begin
         if (gap_at > 0 && n == gap_at) begin
            ena = 1'b0;
            repeat (5) tick();
            n += 5;
            ena = 1'b1;
         end else begin
            tick();
            n++;
         end
      end
      checks++;
      if (n != exp_lat) begin
         errors++;
         $display("FAIL latency got %0d want %0d", n, exp_lat);
      end
      for (int i = 0; i < 4; i++) begin
         w = 0;
         while (out_valid !== 1'b1 && w < 50) begin
            tick();
            w++;
         end
         checks++;
         if (out_valid !== 1'b1 || err !== exp_err) begin
            errors++;
            $display("FAIL send_byte%0d out_valid %b err %b want 1 %b", i, out_valid, err, exp_err);
         end
         if (i == 0 && stall > 0) begin
            b0 = uo_out;
            repeat (stall) begin
               tick();
               checks++;
               if (uo_out !== b0 || out_valid !== 1'b1) begin
                  errors++;
                  $display("FAIL stall_hold uo_out %h out_valid %b want %h 1", uo_out, out_valid, b0);
               end
            end
         end
         r[8*i +: 8] = uo_out;
         uio_in[1] = 1'b1;
         tick();
         uio_in[1] = 1'b0;
      end
      checks++;
      if (busy !== 1'b0 || in_ready !== 1'b1 || err !== 1'b0 || uo_out !== 8'h00) begin
         errors++;
         $display("FAIL back_to_idle busy %b in_ready %b err %b uo_out %h want 0 1 0 00",
                  busy, in_ready, err, uo_out);
      end
   endtask

   task automatic run_txn(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int gap_at, input int stall, output logic [31:0] r);
      logic [31:0] exp;
      exp = model(op, a, b);
      send_frame(op, a, b);
      get_result(op, (gap_at > 0) ? 38 : 33, gap_at, stall, r);
      checks++;
      if (r !== exp) begin
         errors++;
         $display("FAIL result op %h a %h b %h got %h want %h", op, a, b, r, exp);
      end
   endtask

   task automatic test_reset;
      #1;
      checks++;
      if (uo_out !== 8'h00 || uio_out !== 8'h00 || uio_oe !== 8'b0011_1100) begin
         errors++;
         $display("FAIL reset_outputs uo_out %h uio_out %h uio_oe %h want 00 00 3c", uo_out, uio_out, uio_oe);
      end
      tick();
      rst_n = 1'b1;
      tick();
      checks++;
      if (uio_out !== 8'h04) begin
         errors++;
         $display("FAIL after_reset uio_out %h want 04", uio_out);
      end
   endtask

   task automatic test_directed;
      logic [31:0] r;
      run_txn(8'h00, 32'd7, 32'd6, 0, 0, r);
      checks++;
      if (r !== 32'h0000_002A) begin errors++; $display("FAIL mul_7x6 got %h want 0000002a", r); end
      run_txn(8'h03, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, r);
      checks++;
      if (r !== 32'hFFFF_FFFE) begin errors++; $display("FAIL mulhu_ones got %h want fffffffe", r); end
      run_txn(8'h01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, r);
      checks++;
      if (r !== 32'h0000_0000) begin errors++; $display("FAIL mulh_ones got %h want 00000000", r); end
      run_txn(8'h02, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, r);
      checks++;
      if (r !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mulhsu_ones got %h want ffffffff", r); end
      run_txn(8'h04, 32'h1234_5678, 32'h9ABC_DEF0, 0, 0, r);
      checks++;
      if (r !== 32'h0000_0000) begin errors++; $display("FAIL bad_opcode got %h want 00000000", r); end
   endtask

   task automatic test_stall;
      logic [31:0] r;
      run_txn(8'h00, 32'h0102_0304, 32'h0000_0105, 0, 10, r);
   endtask

   task automatic test_abort;
      logic [31:0] r;
      send_byte(8'h00);
      send_byte(8'hAA);
      send_byte(8'hBB);
      uio_in[7] = 1'b1;
      uio_in[0] = 1'b1;
      ui_in = 8'hCC;
      tick();
      uio_in = 8'h00;
      ui_in = 8'h00;
      checks++;
      if (busy !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL abort_idle busy %b in_ready %b want 0 1", busy, in_ready);
      end
      uio_in[7] = 1'b1;
      tick();
      uio_in[7] = 1'b0;
      checks++;
      if (busy !== 1'b0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL abort_in_idle busy %b out_valid %b want 0 0", busy, out_valid);
      end
      run_txn(8'h01, 32'h8000_0001, 32'h7FFF_FFFF, 0, 0, r);
   endtask

   task automatic test_ena_gap;
      logic [31:0] r;
      run_txn(8'h02, 32'hDEAD_BEEF, 32'h0BAD_F00D, 12, 0, r);
   endtask

   task automatic test_async_reset;
      logic [31:0] r;
      send_frame(8'h03, 32'hFFFF_0000, 32'h0000_FFFF);
      repeat (10) tick();
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (uo_out !== 8'h00 || uio_out !== 8'h00 || uio_oe !== 8'b0011_1100) begin
         errors++;
         $display("FAIL async_reset uo_out %h uio_out %h uio_oe %h want 00 00 3c", uo_out, uio_out, uio_oe);
      end
      tick();
      rst_n = 1'b1;
      tick();
      checks++;
      if (uio_out !== 8'h04) begin
         errors++;
         $display("FAIL post_async_reset uio_out %h want 04", uio_out);
      end
      run_txn(8'h03, 32'hFFFF_0000, 32'h0000_FFFF, 0, 0, r);
   endtask

   task automatic test_back_to_back;
      logic [31:0] r;
      run_txn(8'h00, 32'hFFFF_FFFF, 32'd2, 0, 0, r);
      run_txn(8'h01, 32'h8000_0000, 32'h8000_0000, 0, 0, r);
   endtask

   task automatic test_random;
      logic [31:0] r, a, b;
      logic [7:0] op;
      for (int i = 0; i < 24; i++) begin
         op = ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'($urandom_range(0, 3));
         case ($urandom_range(0, 3))
            0:       a = 32'h8000_0000;
            1:       a = 32'hFFFF_FFFF;
            default: a = $urandom;
         endcase
         b = ($urandom_range(0, 3) == 0) ? 32'h7FFF_FFFF : $urandom;
         run_txn(op, a, b, 0, ($urandom_range(0, 3) == 0) ? 3 : 0, r);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_stall();
      test_abort();
      test_ena_gap();
      test_async_reset();
      test_back_to_back();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
